vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Timing generator for 640x480 @ 60 Hz VGA on the Basys 3 100 MHz clock.
- Sits directly upstream of the text/overlay display stages (game-over screen, score, etc.).
- Produces pixel tick, horizontal/vertical pixel coordinates x/y, video_on blanking flag, active-low hsync/vsync, and a frame_start pulse.
- Every display stage consumes x, y and video_on from this block; hsync/vsync go straight to the VGA connector.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); legal values are 2 or greater

Ports:
- clk  input  1  system clock, 100 MHz, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- p_tick  output  1  one-clk pulse per pixel period
- x  output  10  horizontal counter, 0..H_TOTAL-1
- y  output  10  vertical counter, 0..V_TOTAL-1
- video_on  output  1  high when x<H_DISPLAY and y<V_DISPLAY
- hsync  output  1  active-low horizontal sync
- vsync  output  1  active-low vertical sync
- frame_start  output  1  one-clk pulse when counters wrap to (0,0)

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Tick divider:
  - div counter, width clog2(TICK_DIV), increments every clk and wraps at TICK_DIV-1.
  - p_tick = 1 exactly when div == TICK_DIV-1, giving a period of TICK_DIV clks and a duty of 1 clk.
- Horizontal counter: advances only on clks where p_tick=1. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on a p_tick clk where x == H_TOTAL-1. At V_TOTAL-1 (with x == H_TOTAL-1) it wraps to 0.
- Next-state values: h_next/v_next are the counter values after the current clk edge.
- hsync, vsync and video_on are registered and computed from h_next/v_next every clk, so they are always aligned with x/y. There is zero cycle skew between coordinates and flags.
- Sync decode:
  - hsync = 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- frame_start: registered, asserted for one clk on the clk where x,y become (0,0) through wrap. It is not asserted on reset release.
- Reset (reset_n=0 sampled on a clk edge):
  - div=0, x=0, y=0, p_tick=0, hsync=1, vsync=1, video_on=0, frame_start=0.
  - Reset overrides every other condition, including mid-line and mid-sync; hsync/vsync return high on that same edge.
- After reset release:
  - First edge: video_on=1 (x=0,y=0), hsync=vsync=1.
  - First p_tick occurs TICK_DIV clks after release.
- Boundaries:
  - x=639 gives video_on=1; x=640 gives video_on=0.
  - y=479 gives video_on=1; y=480 gives video_on=0 for the entire line.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Out-of-range values are impossible by construction.
- Widths: x/y are 10 bits, sufficient for 800/525. Comparisons are unsigned.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480 timing constants (H_DISPLAY … V_BACK, H_TOTAL, V_TOTAL).
  - Derived sync start/end constants.
  - COORD_W=10.
  - The same package is used by display stages for their on-region bounds.
- One natural sub-module, pixel_tick_div: parameter TICK_DIV, ports clk, reset_n, p_tick.
- Counters and the sync decode stay in vga_sync_gen.

Test Plan:
- Reset: hold reset_n=0 for 10 clks -> x=0, y=0, hsync=1, vsync=1, video_on=0, p_tick=0, frame_start=0. Release -> video_on=1 next edge; first p_tick 4 clks later, then every 4 clks.
- Line timing: run one line -> x counts 0..799 then 0, with y incremented on the wrap edge. hsync is low for exactly 96 ticks (384 clks), starting at x=656 and ending after x=751.
- Blanking edges: check video_on=1 at (639,0), 0 at (640,0), 1 at (0,479), 0 at (0,480) and for all x on y=480..524.
- Frame timing: run a full frame -> vsync is low only for y=490..491 (1600 ticks). At (799,524) -> next tick gives (0,0) with frame_start high for exactly 1 clk; frame period is 420000 ticks (1680000 clks).
- Mid-operation reset: assert reset_n=0 at x=700, y=491 (hsync and vsync both low) -> on that edge x=y=0 and hsync=vsync=1. No frame_start pulse occurs on release.
- Parameter override: instantiate with TICK_DIV=2, H_DISPLAY=8, H_FRONT=H_SYNC=H_BACK=2, V_* = 4/1/1/1 -> x wraps at 13, y wraps at 6, and p_tick period is 2 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// 640x480 @ 60 Hz VGA timing constants shared by the sync generator and the
// downstream display stages that need the visible-region bounds.
package vga_pkg;

    localparam int COORD_W   = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a one-clk-wide pixel enable every
// TICK_DIV clks; the enable is high on the last count of each period.
module pixel_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int                DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_div <= '0;
        else if (r_div == DIV_MAX)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    assign p_tick = (r_div == DIV_MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel coordinates plus blanking/sync/frame flags, all
// registered from the next-state coordinates so they line up with x/y.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam coord_t H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   w_p_tick;
    logic   w_h_wrap;
    logic   w_v_wrap;
    coord_t w_x_next;
    coord_t w_y_next;

    coord_t r_x;
    coord_t r_y;
    logic   r_video_on;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_start;

    pixel_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (w_p_tick)
    );

    assign w_h_wrap = w_p_tick && (r_x == H_LAST);
    assign w_v_wrap = w_h_wrap && (r_y == V_LAST);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            if (w_h_wrap) begin
                w_x_next = '0;
                w_y_next = w_v_wrap ? '0 : r_y + 1'b1;
            end else begin
                w_x_next = r_x + 1'b1;
            end
        end
    end

    // Flags decode the post-edge coordinates so they never trail x/y by a clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_video_on    <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_video_on    <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
            r_hsync       <= !((w_x_next >= HS_START) && (w_x_next <= HS_END));
            r_vsync       <= !((w_y_next >= VS_START) && (w_y_next <= VS_END));
            r_frame_start <= w_v_wrap;
        end
    end

    assign p_tick      = w_p_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Checks a default-timing and a shrunken-timing instance every clk against a
// model that derives position from elapsed clks since reset release.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, rst_s;
    logic       d_p_tick, d_video_on, d_hsync, d_vsync, d_frame_start;
    logic [9:0] d_x, d_y;
    logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_start;
    logic [9:0] s_x, s_y;

    vga_sync_gen u_dflt (
        .clk         (clk),
        .reset_n     (rst_d),
        .p_tick      (d_p_tick),
        .x           (d_x),
        .y           (d_y),
        .video_on    (d_video_on),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .frame_start (d_frame_start)
    );

    vga_sync_gen #(
        .TICK_DIV (2),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .clk         (clk),
        .reset_n     (rst_s),
        .p_tick      (s_p_tick),
        .x           (s_x),
        .y           (s_y),
        .video_on    (s_video_on),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .frame_start (s_frame_start)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Elapsed clk edges since reset release; inr marks "last edge saw reset".
    int c_d = 0, c_s = 0;
    bit inr_d = 1'b1, inr_s = 1'b1;
    int hs_low_d = 0, fs_cnt_s = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input int c, input bit inr, input int td,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb);
        int n, ht, vt, px, py;
        logic pt, fs, vo, hsy, vsy;
        if (inr) return {7'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        n   = c / td;
        px  = n % ht;
        py  = (n / ht) % vt;
        pt  = (c % td) == td - 1;
        fs  = (c > 0) && (c % td == 0) && (n % (ht * vt) == 0);
        vo  = (px < hd) && (py < vd);
        hsy = !((px >= hd + hf) && (px < hd + hf + hs));
        vsy = !((py >= vd + vf) && (py < vd + vf + vs));
        return {7'b0, pt, fs, vo, hsy, vsy, 10'(px), 10'(py)};
    endfunction

    function automatic logic [31:0] m_dflt();
        return model(c_d, inr_d, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [31:0] m_small();
        return model(c_s, inr_s, 2, 8, 2, 2, 2, 4, 1, 1, 1);
    endfunction

    // One clk: drive resets, take the edge, advance models, check at negedge.
    task automatic step(input bit rd, input bit rs);
        rst_d = rd;
        rst_s = rs;
        @(posedge clk);
        if (!rd) begin c_d = 0; inr_d = 1'b1; end else begin c_d++; inr_d = 1'b0; end
        if (!rs) begin c_s = 0; inr_s = 1'b1; end else begin c_s++; inr_s = 1'b0; end
        @(negedge clk);
        chk("dflt", {7'b0, d_p_tick, d_frame_start, d_video_on, d_hsync, d_vsync, d_x, d_y}, m_dflt());
        chk("small", {7'b0, s_p_tick, s_frame_start, s_video_on, s_hsync, s_vsync, s_x, s_y}, m_small());
        if (d_hsync === 1'b0) hs_low_d++;
        if (s_frame_start === 1'b1) fs_cnt_s++;
    endtask

    initial begin
        bit found;
        rst_d = 1'b0;
        rst_s = 1'b0;

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // One full default line; small instance wraps many frames meanwhile.
        hs_low_d = 0;
        fs_cnt_s = 0;
        for (int i = 0; i < 3200; i++) step(1'b1, 1'b1);
        chk("hs_low_clks", 32'(hs_low_d), 32'd384);
        chk("fs_count_small", 32'(fs_cnt_s), 32'(3200 / (14 * 7 * 2)));
        chk("y_after_line", 32'(d_y), 32'd1);

        // Reset the small instance while both syncs are low.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (s_x == 10'd10 && s_y == 10'd5 && s_hsync === 1'b0 && s_vsync === 1'b0) found = 1'b1;
            else step(1'b1, 1'b1);
        end
        chk("wait_small_sync", 32'(found), 32'd1);
        step(1'b1, 1'b0);
        chk("small_rst_sync", {30'b0, s_hsync, s_vsync}, 32'd3);
        step(1'b1, 1'b1);
        chk("small_rel_fs", 32'(s_frame_start), 32'd0);

        // Reset the default instance mid-hsync.
        found = 1'b0;
        for (int i = 0; i < 3400 && !found; i++) begin
            if (d_x == 10'd700) found = 1'b1;
            else step(1'b1, 1'b1);
        end
        chk("wait_dflt_x700", 32'(found), 32'd1);
        chk("dflt_x700_hsync", 32'(d_hsync), 32'd0);
        step(1'b0, 1'b1);
        chk("dflt_rst_xy", {d_hsync, 11'b0, d_x, d_y}, {1'b1, 31'b0});
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

        // Random run lengths with sporadic resets on either instance.
        for (int k = 0; k < 15; k++) begin
            int len;
            len = $urandom_range(50, 2500);
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 999) != 0, $urandom_range(0, 299) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
